// File: rtl/health_alarm_reporter.sv
// health_alarm_reporter
//   Consumer of the phase-1 abnormality detector flags. Each raw flag must stay
//   high for PERSIST consecutive samples before it is confirmed. A flag clears on
//   the first low sample. Every confirm or clear transition becomes an event record
//   {source, raise/clear, glycemicIndex snapshot}. The record waits in a per-source
//   pending slot, is pushed into a small FWFT FIFO by a fixed-priority arbiter, and
//   is delivered to the nurse-station link over a valid/ready handshake.
//
// Ports
//   clk, rst_n            system clock (rising edge), async active-low reset
//   presureAbnormality    raw flag, source 0
//   bloodAbnormality      raw flag, source 1
//   lowTempAbnormality    raw flag, source 2
//   highTempAbnormality   raw flag, source 3
//   fallDetected          raw flag, source 4
//   glycemicIndex [3:0]   snapshot attached to each event
//   evtValid / evtReady   FIFO head handshake; a pop occurs when both are high
//   evtCode [2:0]         source id of the head event
//   evtRaise              1 = confirm event, 0 = clear event
//   evtGI [3:0]           glycemicIndex captured when the event was created
//   activeMask [4:0]      confirmed state per source
//   alarmActive           OR of activeMask
//   overflow              sticky flag: a pending event was overwritten

module health_alarm_reporter #(
    parameter int PERSIST    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       presureAbnormality,
    input  logic       bloodAbnormality,
    input  logic       lowTempAbnormality,
    input  logic       highTempAbnormality,
    input  logic       fallDetected,
    input  logic [3:0] glycemicIndex,
    output logic       evtValid,
    input  logic       evtReady,
    output logic [2:0] evtCode,
    output logic       evtRaise,
    output logic [3:0] evtGI,
    output logic [4:0] activeMask,
    output logic       alarmActive,
    output logic       overflow
);

    localparam int CW = $clog2(PERSIST + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH + 1);

    logic [4:0]    raw;
    logic [CW-1:0] cnt [5];
    logic [4:0]    confirmed;
    logic [4:0]    confirmedNext;
    logic [4:0]    newEvt;

    logic [4:0]    pending;
    logic [4:0]    pendRaise;
    logic [3:0]    pendGI [5];

    logic [2:0]    memCode  [FIFO_DEPTH];
    logic          memRaise [FIFO_DEPTH];
    logic [3:0]    memGI    [FIFO_DEPTH];
    logic [PW-1:0] wrPtr;
    logic [PW-1:0] rdPtr;
    logic [NW-1:0] count;

    logic [2:0]    selId;
    logic          anyPend;
    logic          fifoFull;
    logic          pop;
    logic          push;

    assign raw = {fallDetected, highTempAbnormality, lowTempAbnormality,
                  bloodAbnormality, presureAbnormality};

    // confirmedNext is the value confirmed takes on this edge. A flag confirms
    // on the sample that brings its counter to PERSIST. Any difference from the
    // current confirmed state creates an event.
    always_comb begin
        confirmedNext = '0;
        for (int n = 0; n < 5; n++) begin
            confirmedNext[n] = raw[n] & (confirmed[n] | (cnt[n] == CW'(PERSIST - 1)));
        end
    end

    assign newEvt = confirmedNext ^ confirmed;

    // Fixed priority. Later iterations win, so source 4 has the highest priority.
    always_comb begin
        selId   = '0;
        anyPend = 1'b0;
        for (int n = 0; n < 5; n++) begin
            if (pending[n]) begin
                selId   = 3'(n);
                anyPend = 1'b1;
            end
        end
    end

    assign evtValid = (count != '0);
    assign fifoFull = (count == NW'(FIFO_DEPTH));
    assign pop      = evtValid & evtReady;
    assign push     = anyPend & (~fifoFull | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < 5; n++) begin
                cnt[n]    <= '0;
                pendGI[n] <= '0;
            end
            confirmed <= '0;
            pending   <= '0;
            pendRaise <= '0;
            overflow  <= 1'b0;
        end else begin
            confirmed <= confirmedNext;
            for (int n = 0; n < 5; n++) begin
                if (!raw[n]) begin
                    cnt[n] <= '0;
                end else if (cnt[n] != CW'(PERSIST)) begin
                    cnt[n] <= cnt[n] + CW'(1);
                end

                // When a new event arrives on the edge that pushes the old one,
                // the old record still reaches the FIFO, so nothing is lost and
                // overflow stays clear.
                if (newEvt[n]) begin
                    pending[n]   <= 1'b1;
                    pendRaise[n] <= confirmedNext[n];
                    pendGI[n]    <= glycemicIndex;
                    if (pending[n] && !(push && selId == 3'(n))) begin
                        overflow <= 1'b1;
                    end
                end else if (push && selId == 3'(n)) begin
                    pending[n] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + NW'(1);
                2'b01:   count <= count - NW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset. The head outputs are gated by evtValid, so stale
    // entries never show on the outputs.
    always_ff @(posedge clk) begin
        if (push) begin
            memCode[wrPtr]  <= selId;
            memRaise[wrPtr] <= pendRaise[selId];
            memGI[wrPtr]    <= pendGI[selId];
        end
    end

    assign evtCode     = evtValid ? memCode[rdPtr]  : 3'd0;
    assign evtRaise    = evtValid ? memRaise[rdPtr] : 1'b0;
    assign evtGI       = evtValid ? memGI[rdPtr]    : 4'd0;
    assign activeMask  = confirmed;
    assign alarmActive = |confirmed;

endmodule
